// File: rtl/xm_uart_pkg.sv
// xm_uart_pkg: definitions shared by the xm_uart receiver and transmitter.
//   - baud index constants for the 3-bit baud_set encoding
//   - baud_div(): terminal count of the baud tick divider
//   - FSM state encoding, frame length and oversampling ratio
package xm_uart_pkg;

  localparam int BAUD_9600   = 0;
  localparam int BAUD_19200  = 1;
  localparam int BAUD_38400  = 2;
  localparam int BAUD_57600  = 3;
  localparam int BAUD_115200 = 4;

  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;  // wide enough for 9600 baud at x1 from 50 MHz

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_fsm_t;

  // Terminal count = round(clk_hz / (baud * oversample)) - 1.
  // Codes outside 0..4 fall back to 9600 baud.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input int baud_set,
                                                input int oversample);
    int baud;
    int step;
    int div;
    case (baud_set)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    step = baud * oversample;
    div  = (clk_hz + step / 2) / step - 1;
    return DIV_W'(div);
  endfunction

endpackage

// File: rtl/xm_uart_baud_gen.sv
// xm_uart_baud_gen: programmable tick divider.
// Counts 0..div and emits a one-cycle tick when the count equals div, then
// wraps to 0. clr restarts the count so the next tick arrives div+1 cycles
// later, aligning the tick grid to an external event (e.g. a start edge).
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clr   - synchronous restart of the divider
//   div   - terminal count
//   tick  - one-cycle strobe every div+1 cycles
module xm_uart_baud_gen
  import xm_uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg >= div) begin
      // >= rather than == so a smaller div loaded mid-count still wraps
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = !clr && (cnt_reg >= div);

endmodule

// File: rtl/xm_uart_rx.sv
// xm_uart_rx: 8N1 UART receiver, LSB first, 16x oversampling with a
// 3-sample majority vote per bit.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   baud_set   - baud select (0=9600 .. 4=115200, 5..7 = 9600), latched at start
//   rs232_rx   - asynchronous serial input, idles high
//   data_byte  - last received byte, held until the next rx_done
//   rx_done    - one-cycle strobe when a frame completes
//   uart_state - high while a frame is being received
//   frame_err  - 1 when the last frame's stop bit voted 0
module xm_uart_rx
  import xm_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       uart_state,
  output logic       frame_err
);

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;   // vote taken here
  localparam logic [3:0] LAST_SUB = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  // Divider terminal counts for every baud_set code, folded to constants.
  logic [DIV_W-1:0] div_table [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div
      assign div_table[gi] = baud_div(CLK_HZ, gi, OVERSAMPLE);
    end
  endgenerate

  // sync_reg[0..1] synchronize, sync_reg[2] holds the previous synced value.
  logic [2:0] sync_reg;
  logic [1:0] settle_reg;
  logic       rx_s;
  logic       start_edge;

  uart_fsm_t  state_reg, state_next;
  logic [7:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] baud_reg, baud_next;
  logic [7:0] shift_reg, shift_next;
  logic [1:0] samp_reg, samp_next;
  logic [7:0] data_byte_reg, data_byte_next;
  logic       frame_err_reg, frame_err_next;
  logic       rx_done_reg, rx_done_next;

  logic       baud_clr;
  logic       tick;
  logic [3:0] sub_tick;
  logic [3:0] bit_idx;
  logic       vote;

  xm_uart_baud_gen u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .div  (div_table[baud_reg]),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg   <= 3'b111;
      settle_reg <= 2'd0;
    end else begin
      sync_reg <= {sync_reg[1:0], rs232_rx};
      if (settle_reg != 2'd3) begin
        settle_reg <= settle_reg + 2'd1;
      end
    end
  end

  assign rx_s = sync_reg[1];

  // The 1s loaded at reset are not real line samples. An edge is only
  // trusted once all three flops hold sampled data, so a line that is low
  // when reset releases (mid-frame or break) cannot fake a start bit.
  assign start_edge = sync_reg[2] && !sync_reg[1] && (settle_reg == 2'd3);

  assign sub_tick = tick_cnt_reg[3:0];
  assign bit_idx  = tick_cnt_reg[7:4];

  // Two stored samples plus the live one at the third sub-tick.
  assign vote = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      baud_reg      <= '0;
      shift_reg     <= '0;
      samp_reg      <= '0;
      data_byte_reg <= '0;
      frame_err_reg <= 1'b0;
      rx_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      baud_reg      <= baud_next;
      shift_reg     <= shift_next;
      samp_reg      <= samp_next;
      data_byte_reg <= data_byte_next;
      frame_err_reg <= frame_err_next;
      rx_done_reg   <= rx_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    baud_next      = baud_reg;
    shift_next     = shift_reg;
    samp_next      = samp_reg;
    data_byte_next = data_byte_reg;
    frame_err_next = frame_err_reg;
    rx_done_next   = 1'b0;
    baud_clr       = 1'b0;

    if (state_reg == ST_IDLE) begin
      if (start_edge) begin
        // Restart the tick grid on the edge so sample points are centred.
        state_next    = ST_START;
        tick_cnt_next = '0;
        baud_next     = baud_set;
        baud_clr      = 1'b1;
      end
    end else if (tick) begin
      tick_cnt_next = tick_cnt_reg + 8'd1;
      if (sub_tick == SAMPLE_A) samp_next[0] = rx_s;
      if (sub_tick == SAMPLE_B) samp_next[1] = rx_s;

      case (state_reg)
        ST_START: begin
          if (sub_tick == SAMPLE_C && vote) begin
            // Start bit did not hold low: a glitch, not a frame.
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
          end else if (sub_tick == LAST_SUB) begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sub_tick == SAMPLE_C) begin
            shift_next = {vote, shift_reg[7:1]};
          end
          if (bit_idx == LAST_DATA_BIT && sub_tick == LAST_SUB) begin
            state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          // Finish at the stop-bit vote instead of the bit end; the slack
          // absorbs back-to-back frames and transmitter baud error.
          if (sub_tick == SAMPLE_C) begin
            data_byte_next = shift_reg;
            frame_err_next = ~vote;
            rx_done_next   = 1'b1;
            state_next     = ST_IDLE;
            tick_cnt_next  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_byte  = data_byte_reg;
  assign rx_done    = rx_done_reg;
  assign frame_err  = frame_err_reg;
  assign uart_state = (state_reg != ST_IDLE);

endmodule
